// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, result record and segment-width helper for the ALU datapath
package alu_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int ALU_W = 32;
  typedef struct packed {
    logic [ALU_W-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } alu_res_t;
  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result valid-ready bus of the pipelined adder
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/adder_segment.sv
// adder_segment: combinational SEG-bit ripple chain of full-adder cells
module adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           c_in,
  output logic [SEG-1:0] s_seg,
  output logic           c_out,
  output logic           c_msb_in
);
  logic [SEG:0] w_c;
  // one full-adder cell per bit, carry rippling upward
  always_comb begin
    w_c    = '0;
    s_seg  = '0;
    w_c[0] = c_in;
    for (int i = 0; i < SEG; i++) begin
      s_seg[i]  = a_seg[i] ^ b_seg[i] ^ w_c[i];
      w_c[i+1]  = (a_seg[i] & b_seg[i]) | (w_c[i] & (a_seg[i] ^ b_seg[i]));
    end
  end
  assign c_out    = w_c[SEG];
  assign c_msb_in = w_c[SEG-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: segmented ripple-carry add/sub, one segment and one carry register per stage
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic               clk,
  input logic               rst,
  pipelined_addsub_if.slave bus
);
  localparam int SEG = seg_w(WIDTH, STAGES);
  localparam int L   = STAGES - 1;
  logic             r_v   [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_ovf;
  logic             w_v   [STAGES];
  logic [WIDTH-1:0] w_a   [STAGES];
  logic [WIDTH-1:0] w_b   [STAGES];
  logic [WIDTH-1:0] w_si  [STAGES];
  logic [WIDTH-1:0] w_sn  [STAGES];
  logic             w_ci  [STAGES];
  logic             w_co  [STAGES];
  logic             w_cm  [STAGES];
  logic [SEG-1:0]   w_seg [STAGES];
  logic             w_stall;
  assign w_stall       = r_v[L] & ~bus.out_ready;
  assign bus.in_ready  = ~w_stall;
  assign bus.out_valid = r_v[L];
  assign bus.sum       = r_s[L];
  assign bus.cout      = r_c[L];
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_v[L] & ~|r_s[L];
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    localparam logic [WIDTH-1:0] M = ({WIDTH{1'b1}} >> (WIDTH - SEG)) << (k * SEG);
    if (k == 0) begin : g_in
      assign w_v[0]  = bus.in_valid & ~w_stall;
      assign w_a[0]  = bus.a;
      assign w_b[0]  = (bus.sub == OP_ADD) ? bus.b : ~bus.b;
      assign w_ci[0] = bus.cin ^ (bus.sub == OP_SUB);
      assign w_si[0] = '0;
    end else begin : g_fw
      assign w_v[k]  = r_v[k-1];
      assign w_a[k]  = r_a[k-1];
      assign w_b[k]  = r_b[k-1];
      assign w_ci[k] = r_c[k-1];
      assign w_si[k] = r_s[k-1];
    end
    adder_segment #(.SEG(SEG)) u_seg (
      .a_seg    (w_a[k][k*SEG +: SEG]),
      .b_seg    (w_b[k][k*SEG +: SEG]),
      .c_in     (w_ci[k]),
      .s_seg    (w_seg[k]),
      .c_out    (w_co[k]),
      .c_msb_in (w_cm[k])
    );
    assign w_sn[k] = (w_si[k] & ~M) | (WIDTH'(w_seg[k]) << (k * SEG));
  end
  // advance all stages unless stalled; bubbles move valid=0 but leave data untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_v[i] <= 1'b0;
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_s[i] <= '0;
        r_c[i] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (!w_stall) begin
      for (int i = 0; i < STAGES; i++) begin
        r_v[i] <= w_v[i];
        if (w_v[i]) begin
          r_a[i] <= w_a[i];
          r_b[i] <= w_b[i];
          r_s[i] <= w_sn[i];
          r_c[i] <= w_co[i];
        end
      end
      if (w_v[L]) r_ovf <= w_co[L] ^ w_cm[L];
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: vector table, random scoreboard stream, stall/reset sequences and stage sweep
module tb_pipelined_addsub;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pipelined_addsub_if #(.WIDTH(8))  m   ();
  pipelined_addsub_if #(.WIDTH(32)) s1  ();
  pipelined_addsub_if #(.WIDTH(32)) s4  ();
  pipelined_addsub_if #(.WIDTH(32)) s32 ();
  pipelined_addsub #(.WIDTH(8),  .STAGES(2))  u_dut (.clk(clk), .rst(rst), .bus(m));
  pipelined_addsub #(.WIDTH(32), .STAGES(1))  u_s1  (.clk(clk), .rst(rst), .bus(s1));
  pipelined_addsub #(.WIDTH(32), .STAGES(4))  u_s4  (.clk(clk), .rst(rst), .bus(s4));
  pipelined_addsub #(.WIDTH(32), .STAGES(32)) u_s32 (.clk(clk), .rst(rst), .bus(s32));
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;
  vec_t tv [9];
  int errors = 0;
  int checks = 0;
  int to_send = 0;
  bit acc = 1'b0;
  int cyc = 0;
  int n_out = 0;
  int first_out = -1;
  int last_out = -1;
  int ir_low = 0;
  logic [10:0] q [$];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [10:0] model8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int ua, ub, sa, sb, ci, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = int'(cin);
    r  = sub ? ua - ub - ci : ua + ub + ci;
    sr = sub ? sa - sb - ci : sa + sb + ci;
    return {((r & 255) == 0), (sr > 127 || sr < -128), (sub ? r >= 0 : r > 255), 8'(r)};
  endfunction
  task automatic tick(input bit rdy);
    logic [10:0] e;
    @(negedge clk);
    if (!(m.in_valid && !acc)) begin
      if (to_send > 0) begin
        m.a = 8'($urandom);
        m.b = 8'($urandom);
        m.cin = 1'($urandom);
        m.sub = 1'($urandom);
        m.in_valid = 1'b1;
        to_send--;
      end else m.in_valid = 1'b0;
    end
    m.out_ready = rdy;
    #1;
    if (!m.in_ready) ir_low++;
    acc = m.in_valid && m.in_ready;
    if (acc) q.push_back(model8(m.a, m.b, m.cin, m.sub));
    if (m.out_valid && m.out_ready) begin
      if (q.size() == 0) chk("spurious output", 64'(m.sum), 64'hxx);
      else begin
        e = q.pop_front();
        chk("stream result", 64'({m.zero, m.ovf, m.cout, m.sum}), 64'(e));
      end
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      n_out++;
    end
    cyc++;
  endtask
  task automatic run_single(input vec_t v, output int lat);
    @(negedge clk);
    m.a = v.a;
    m.b = v.b;
    m.cin = v.cin;
    m.sub = v.sub;
    m.in_valid = 1'b1;
    m.out_ready = 1'b1;
    @(posedge clk);
    #1 m.in_valid = 1'b0;
    lat = 1;
    while (!m.out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1);
  end
  initial begin
    int lat, l1, l4, l32, n0;
    logic [34:0] r1, r4, r32;
    logic [10:0] snap;
    tv[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tv[1] = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tv[2] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tv[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tv[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    tv[5] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tv[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tv[7] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tv[8] = '{8'h80, 8'h7F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
    m.in_valid = 1'b0; m.a = '0; m.b = '0; m.cin = 1'b0; m.sub = 1'b0; m.out_ready = 1'b1;
    s1.in_valid = 1'b0; s1.a = '0; s1.b = '0; s1.cin = 1'b0; s1.sub = 1'b0; s1.out_ready = 1'b1;
    s4.in_valid = 1'b0; s4.a = '0; s4.b = '0; s4.cin = 1'b0; s4.sub = 1'b0; s4.out_ready = 1'b1;
    s32.in_valid = 1'b0; s32.a = '0; s32.b = '0; s32.cin = 1'b0; s32.sub = 1'b0; s32.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("reset out_valid", 64'(m.out_valid), 64'd0);
    chk("reset fields", 64'({m.zero, m.ovf, m.cout, m.sum}), 64'd0);
    chk("reset in_ready", 64'(m.in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_single(tv[i], lat);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d sum", i), 64'(m.sum), 64'(tv[i].s));
      chk($sformatf("vec%0d cout", i), 64'(m.cout), 64'(tv[i].co));
      chk($sformatf("vec%0d ovf", i), 64'(m.ovf), 64'(tv[i].ov));
      chk($sformatf("vec%0d zero", i), 64'(m.zero), 64'(tv[i].z));
      @(posedge clk);
      #1 chk($sformatf("vec%0d single beat", i), 64'(m.out_valid), 64'd0);
    end
    to_send = 16;
    ir_low = 0;
    first_out = -1;
    n0 = n_out;
    for (int i = 0; i < 24; i++) tick(1'b1);
    chk("stream count", 64'(n_out - n0), 64'd16);
    chk("stream one per cycle", 64'(last_out - first_out), 64'd15);
    chk("stream in_ready low cycles", 64'(ir_low), 64'd0);
    chk("stream drained", 64'(q.size()), 64'd0);
    to_send = 3;
    for (int i = 0; i < 3; i++) tick(1'b0);
    snap = {m.zero, m.ovf, m.cout, m.sum};
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      chk("stall in_ready", 64'(m.in_ready), 64'd0);
      chk("stall out_valid", 64'(m.out_valid), 64'd1);
      chk("stall fields held", 64'({m.zero, m.ovf, m.cout, m.sum}), 64'(snap));
    end
    n0 = n_out;
    for (int i = 0; i < 10; i++) tick(1'b1);
    chk("release count", 64'(n_out - n0), 64'd3);
    chk("release drained", 64'(q.size()), 64'd0);
    to_send = 2;
    tick(1'b1);
    tick(1'b1);
    @(negedge clk);
    chk("pre-reset out_valid", 64'(m.out_valid), 64'd1);
    m.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async reset out_valid", 64'(m.out_valid), 64'd0);
    chk("async reset fields", 64'({m.zero, m.ovf, m.cout, m.sum}), 64'd0);
    q.delete();
    acc = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 6; i++) tick(1'b1);
    chk("flushed beats not emitted", 64'(n_out - n0), 64'd0);
    to_send = 1;
    for (int i = 0; i < 6; i++) tick(1'b1);
    chk("post-reset beat", 64'(n_out - n0), 64'd1);
    @(negedge clk);
    s1.a = 32'hFFFF_FFFF; s4.a = 32'hFFFF_FFFF; s32.a = 32'hFFFF_FFFF;
    s1.b = 32'h1; s4.b = 32'h1; s32.b = 32'h1;
    s1.in_valid = 1'b1; s4.in_valid = 1'b1; s32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    s1.in_valid = 1'b0; s4.in_valid = 1'b0; s32.in_valid = 1'b0;
    l1 = 0; l4 = 0; l32 = 0; r1 = '0; r4 = '0; r32 = '0;
    for (int e = 1; e <= 40; e++) begin
      if (s1.out_valid && l1 == 0) begin l1 = e; r1 = {s1.zero, s1.ovf, s1.cout, s1.sum}; end
      if (s4.out_valid && l4 == 0) begin l4 = e; r4 = {s4.zero, s4.ovf, s4.cout, s4.sum}; end
      if (s32.out_valid && l32 == 0) begin l32 = e; r32 = {s32.zero, s32.ovf, s32.cout, s32.sum}; end
      @(posedge clk);
      #1;
    end
    chk("sweep s1 latency", 64'(l1), 64'd1);
    chk("sweep s4 latency", 64'(l4), 64'd4);
    chk("sweep s32 latency", 64'(l32), 64'd32);
    chk("sweep s1 result", 64'(r1), {29'd0, 35'h5_0000_0000 | 35'h1_0000_0000});
    chk("sweep s4 result", 64'(r4), {29'd0, 35'h5_0000_0000 | 35'h1_0000_0000});
    chk("sweep s32 result", 64'(r32), {29'd0, 35'h5_0000_0000 | 35'h1_0000_0000});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
